// File: rtl/arp_rx_multi_if.sv
// GMII receive input and ARP parse results, bundled between the PHY side and the ARP TX/cache side.
interface arp_rx_multi_if #(
  parameter int IDX_W  = 3,
  parameter int DROP_W = 16
);
  logic              gmii_rx_dv;
  logic [7:0]        gmii_rxd;
  logic              arp_rx_done;
  logic              arp_rx_type;
  logic              arp_gratuitous;
  logic [IDX_W-1:0]  ip_idx;
  logic [47:0]       src_mac;
  logic [31:0]       src_ip;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output gmii_rx_dv, gmii_rxd,
    input  arp_rx_done, arp_rx_type, arp_gratuitous, ip_idx, src_mac, src_ip, drop_cnt
  );
  modport slave (
    input  gmii_rx_dv, gmii_rxd,
    output arp_rx_done, arp_rx_type, arp_gratuitous, ip_idx, src_mac, src_ip, drop_cnt
  );
endinterface

// File: rtl/arp_rx_multi.sv
// GMII ARP receive parser with a multi-entry local IP table and a saturating drop counter.
// Define ARP_RX_VLAN_EN to accept a single 802.1Q tag ahead of the ARP EtherType.
module arp_rx_multi #(
  parameter logic [47:0]          BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter int                   IP_NUM    = 2,
  parameter logic [32*IP_NUM-1:0] IP_LIST   = {8'd192,8'd168,8'd1,8'd10, 8'd192,8'd168,8'd1,8'd11},
  parameter int                   IDX_W     = 3,
  parameter int                   DROP_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  arp_rx_multi_if.slave bus
);
`ifdef ARP_RX_VLAN_EN
  localparam bit VLAN_EN = 1'b1;
`else
  localparam bit VLAN_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, PREAMBLE, ETH_HEAD, ARP_DATA, RX_END} state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              uc_q, uc_d, bc_q, bc_d, vlan_q, vlan_d, oper2_q, oper2_d;
  logic [7:0]        hi_q, hi_d;
  logic [47:0]       sha_q, sha_d, mac_q, mac_d;
  logic [31:0]       spa_q, spa_d, ip_q, ip_d;
  logic [23:0]       tpa_q, tpa_d;
  logic              done_q, done_d, type_q, type_d, grat_q, grat_d;
  logic [IDX_W-1:0]  idx_q, idx_d, hit_idx;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              drop_inc, hit;
  logic [31:0]       tpa_full;
  logic [15:0]       etype;
  logic [7:0]        mac_byte;

  wire       dv  = bus.gmii_rx_dv;
  wire [7:0] rxd = bus.gmii_rxd;

  function automatic logic hdr_ok(input logic [4:0] i, input logic [7:0] b);
    case (i)
      5'd1:    hdr_ok = (b == 8'h01);
      5'd2:    hdr_ok = (b == 8'h08);
      5'd4:    hdr_ok = (b == 8'h06);
      5'd5:    hdr_ok = (b == 8'h04);
      5'd7:    hdr_ok = (b == 8'h01) || (b == 8'h02);
      default: hdr_ok = (b == 8'h00);
    endcase
  endfunction

  // Target IP is compared while byte 27 is on the bus so results register at that same edge.
  assign tpa_full = {tpa_q, rxd};
  assign etype    = {hi_q, rxd};

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = IP_NUM - 1; i >= 0; i--)
      if (tpa_full == IP_LIST[32*(IP_NUM-1-i) +: 32]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
  end

  always_comb begin
    mac_byte = 8'h00;
    for (int i = 0; i < 6; i++)
      if (cnt_q == 5'(i)) mac_byte = BOARD_MAC[8*(5-i) +: 8];
  end

  always_comb begin
    state_d = state_q;  cnt_d  = cnt_q;  uc_d = uc_q;  bc_d = bc_q;
    vlan_d  = vlan_q;   hi_d   = hi_q;   oper2_d = oper2_q;
    sha_d   = sha_q;    spa_d  = spa_q;  tpa_d = tpa_q;
    done_d  = 1'b0;     type_d = type_q; grat_d = grat_q; idx_d = idx_q;
    mac_d   = mac_q;    ip_d   = ip_q;   drop_inc = 1'b0;
    case (state_q)
      IDLE: if (dv && rxd == 8'h55) begin
        state_d = PREAMBLE;
        cnt_d   = '0;
      end
      PREAMBLE: begin
        if (!dv) state_d = IDLE;
        else if (rxd == 8'h55 && cnt_q < 5'd6) cnt_d = cnt_q + 5'd1;
        else if (rxd == 8'hD5 && cnt_q == 5'd6) begin
          state_d = ETH_HEAD;
          cnt_d   = '0;
          uc_d    = 1'b1;
          bc_d    = 1'b1;
          vlan_d  = 1'b0;
        end else state_d = RX_END;
      end
      ETH_HEAD: begin
        if (!dv) begin
          state_d  = IDLE;
          drop_inc = 1'b1;
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q < 5'd6) begin
            uc_d = uc_q & (rxd == mac_byte);
            bc_d = bc_q & (rxd == 8'hFF);
            if (cnt_q == 5'd5 && !(uc_d || bc_d)) begin
              state_d  = RX_END;
              drop_inc = 1'b1;
            end
          end
          if (cnt_q == 5'd12 || cnt_q == 5'd16) hi_d = rxd;
          // Byte 17 is only reached after a tag at 12/13, so a second 0x8100 there is a drop.
          if (cnt_q == 5'd13 || cnt_q == 5'd17) begin
            if (etype == 16'h0806) begin
              state_d = ARP_DATA;
              cnt_d   = '0;
            end else if (VLAN_EN && etype == 16'h8100 && !vlan_q) vlan_d = 1'b1;
            else begin
              state_d  = RX_END;
              drop_inc = 1'b1;
            end
          end
        end
      end
      ARP_DATA: begin
        if (!dv) begin
          state_d  = IDLE;
          drop_inc = 1'b1;
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) oper2_d = rxd[1];
          if (cnt_q >= 5'd8  && cnt_q <= 5'd13) sha_d = {sha_q[39:0], rxd};
          if (cnt_q >= 5'd14 && cnt_q <= 5'd17) spa_d = {spa_q[23:0], rxd};
          if (cnt_q >= 5'd24) tpa_d = {tpa_q[15:0], rxd};
          if (cnt_q < 5'd8 && !hdr_ok(cnt_q, rxd)) begin
            state_d  = RX_END;
            drop_inc = 1'b1;
          end else if (cnt_q == 5'd27) begin
            state_d = RX_END;
            if (hit) begin
              done_d = 1'b1;
              type_d = oper2_q;
              grat_d = (spa_q == tpa_full);
              idx_d  = hit_idx;
              mac_d  = sha_q;
              ip_d   = spa_q;
            end else drop_inc = 1'b1;
          end
        end
      end
      RX_END: if (!dv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    drop_d = (drop_inc && drop_q != '1) ? drop_q + DROP_W'(1) : drop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE; cnt_q <= '0; uc_q <= 1'b0; bc_q <= 1'b0; vlan_q <= 1'b0;
      hi_q <= '0; oper2_q <= 1'b0; sha_q <= '0; spa_q <= '0; tpa_q <= '0;
      done_q <= 1'b0; type_q <= 1'b0; grat_q <= 1'b0; idx_q <= '0;
      mac_q <= '0; ip_q <= '0; drop_q <= '0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; uc_q <= uc_d; bc_q <= bc_d; vlan_q <= vlan_d;
      hi_q <= hi_d; oper2_q <= oper2_d; sha_q <= sha_d; spa_q <= spa_d; tpa_q <= tpa_d;
      done_q <= done_d; type_q <= type_d; grat_q <= grat_d; idx_q <= idx_d;
      mac_q <= mac_d; ip_q <= ip_d; drop_q <= drop_d;
    end
  end

  assign bus.arp_rx_done    = done_q;
  assign bus.arp_rx_type    = type_q;
  assign bus.arp_gratuitous = grat_q;
  assign bus.ip_idx         = idx_q;
  assign bus.src_mac        = mac_q;
  assign bus.src_ip         = ip_q;
  assign bus.drop_cnt       = drop_q;
endmodule

// File: tb/tb_arp_rx_multi.sv
// Directed bench for arp_rx_multi: table of whole frames plus runt, bad-preamble, reset and saturation sequences.
module tb_arp_rx_multi;
  localparam int IDX_W  = 3;
  localparam int DROP_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arp_rx_multi_if #(.IDX_W(IDX_W), .DROP_W(DROP_W)) bus ();

  arp_rx_multi #(.IDX_W(IDX_W), .DROP_W(DROP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [47:0] dst;
    logic [15:0] ptype;
    logic [7:0]  oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [31:0] tpa;
    logic        vlan;
    logic        ex_done;
    logic        ex_type;
    logic [2:0]  ex_idx;
    logic        ex_grat;
    logic [47:0] ex_mac;
    logic [31:0] ex_ip;
    int          ex_dinc;
  } vec_t;

  vec_t       vt[8];
  logic [7:0] frm[$];
  int checks = 0, fails = 0;
  int ndone, dpos, bidx, exp_drop;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic [7:0] d, input logic r);
    @(negedge clk);
    bus.gmii_rx_dv = dv;
    bus.gmii_rxd   = d;
    rst            = r;
    @(posedge clk);
    #1;
    if (bus.arp_rx_done) begin
      ndone++;
      dpos = bidx;
    end
    bidx++;
  endtask

  task automatic start_frame();
    ndone = 0; dpos = -1; bidx = 0;
  endtask

  task automatic send_range(input int from, input int to);
    for (int k = from; k < to; k++) drive(1'b1, frm[k], 1'b0);
  endtask

  task automatic gap();
    for (int k = 0; k < 4; k++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic build(input vec_t v);
    frm.delete();
    for (int k = 0; k < 7; k++) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int k = 5; k >= 0; k--) frm.push_back(v.dst[8*k +: 8]);
    for (int k = 5; k >= 0; k--) frm.push_back(v.sha[8*k +: 8]);
    if (v.vlan) begin
      frm.push_back(8'h81); frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h05);
    end
    frm.push_back(8'h08); frm.push_back(8'h06);
    frm.push_back(8'h00); frm.push_back(8'h01);
    frm.push_back(v.ptype[15:8]); frm.push_back(v.ptype[7:0]);
    frm.push_back(8'h06); frm.push_back(8'h04);
    frm.push_back(8'h00); frm.push_back(v.oper);
    for (int k = 5; k >= 0; k--) frm.push_back(v.sha[8*k +: 8]);
    for (int k = 3; k >= 0; k--) frm.push_back(v.spa[8*k +: 8]);
    for (int k = 0; k < 6; k++) frm.push_back(8'h00);
    for (int k = 3; k >= 0; k--) frm.push_back(v.tpa[8*k +: 8]);
    frm.push_back(8'hDE); frm.push_back(8'hAD); frm.push_back(8'hBE); frm.push_back(8'hEF);
  endtask

  task automatic chk_out(input string nm, input vec_t v);
    chk({nm, " type"}, 64'(bus.arp_rx_type),    64'(v.ex_type));
    chk({nm, " idx"},  64'(bus.ip_idx),         64'(v.ex_idx));
    chk({nm, " grat"}, 64'(bus.arp_gratuitous), 64'(v.ex_grat));
    chk({nm, " mac"},  64'(bus.src_mac),        64'(v.ex_mac));
    chk({nm, " ip"},   64'(bus.src_ip),         64'(v.ex_ip));
  endtask

  initial begin
    vec_t held, z;
    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rxd   = 8'h00;
    //             dst              ptype    op    sha              spa           tpa          vl  done ty idx gr mac             ip           dinc
    vt[0] = '{48'hFFFFFFFFFFFF, 16'h0800, 8'd1, 48'h000A3501FEC0, 32'hC0A80166, 32'hC0A8010B, 0, 1, 0, 1, 0, 48'h000A3501FEC0, 32'hC0A80166, 0};
    vt[1] = '{48'h001122334455, 16'h0800, 8'd2, 48'h0A0B0C0D0E0F, 32'hC0A8010A, 32'hC0A8010A, 0, 1, 1, 0, 1, 48'h0A0B0C0D0E0F, 32'hC0A8010A, 0};
    vt[2] = '{48'hFFFFFFFFFFFF, 16'h0800, 8'd1, 48'h111111111111, 32'hC0A80102, 32'hC0A80163, 0, 0, 1, 0, 1, 48'h0A0B0C0D0E0F, 32'hC0A8010A, 1};
    vt[3] = '{48'hFFFFFFFFFFFF, 16'h86DD, 8'd1, 48'h111111111111, 32'hC0A80102, 32'hC0A8010A, 0, 0, 1, 0, 1, 48'h0A0B0C0D0E0F, 32'hC0A8010A, 1};
    vt[4] = '{48'hFFFFFFFFFFFF, 16'h0800, 8'd3, 48'h111111111111, 32'hC0A80102, 32'hC0A8010A, 0, 0, 1, 0, 1, 48'h0A0B0C0D0E0F, 32'hC0A8010A, 1};
    vt[5] = '{48'hFFFFFFFFFFFF, 16'h0800, 8'd1, 48'h665544332211, 32'hC0A80105, 32'hC0A8010A, 0, 1, 0, 0, 0, 48'h665544332211, 32'hC0A80105, 0};
    vt[6] = '{48'h001122334456, 16'h0800, 8'd1, 48'h222222222222, 32'hC0A80106, 32'hC0A8010A, 0, 0, 0, 0, 0, 48'h665544332211, 32'hC0A80105, 1};
`ifdef ARP_RX_VLAN_EN
    vt[7] = '{48'h001122334455, 16'h0800, 8'd2, 48'hA1A2A3A4A5A6, 32'hC0A80107, 32'hC0A8010B, 1, 1, 1, 1, 0, 48'hA1A2A3A4A5A6, 32'hC0A80107, 0};
`else
    vt[7] = '{48'h001122334455, 16'h0800, 8'd2, 48'hA1A2A3A4A5A6, 32'hC0A80107, 32'hC0A8010B, 1, 0, 0, 0, 0, 48'h665544332211, 32'hC0A80105, 1};
`endif

    repeat (3) @(posedge clk);
    #1;
    z = vt[0];
    z.ex_type = 0; z.ex_idx = 0; z.ex_grat = 0; z.ex_mac = '0; z.ex_ip = '0;
    chk("reset done", 64'(bus.arp_rx_done), 64'd0);
    chk("reset drop", 64'(bus.drop_cnt), 64'd0);
    chk_out("reset", z);
    exp_drop = 0;

    for (int i = 0; i < 8; i++) begin
      build(vt[i]);
      start_frame();
      send_range(0, frm.size());
      gap();
      exp_drop += vt[i].ex_dinc;
      chk($sformatf("v%0d done count", i), 64'(ndone), 64'(vt[i].ex_done));
      // Done follows the edge that samples ARP byte 27: preamble 8 + header 14 (+4 tagged) + 27.
      if (vt[i].ex_done) chk($sformatf("v%0d done pos", i), 64'(dpos), 64'(vt[i].vlan ? 53 : 49));
      chk($sformatf("v%0d drop", i), 64'(bus.drop_cnt), 64'(exp_drop));
      chk_out($sformatf("v%0d", i), vt[i]);
    end
    held = vt[7];

    // Runt: dv falls after ARP byte 12.
    build(vt[0]);
    start_frame();
    send_range(0, 35);
    gap();
    exp_drop++;
    chk("runt done count", 64'(ndone), 64'd0);
    chk("runt drop", 64'(bus.drop_cnt), 64'(exp_drop));
    chk_out("runt held", held);
    build(vt[1]);
    start_frame();
    send_range(0, frm.size());
    gap();
    chk("post runt done count", 64'(ndone), 64'd1);
    chk_out("post runt", vt[1]);

    // Bad 4th preamble byte: frame swallowed without counting.
    build(vt[0]);
    frm[3] = 8'h12;
    start_frame();
    send_range(0, frm.size());
    gap();
    chk("bad pre done count", 64'(ndone), 64'd0);
    chk("bad pre drop", 64'(bus.drop_cnt), 64'(exp_drop));

    // One-cycle reset while ARP byte 20 is on the bus.
    build(vt[5]);
    start_frame();
    send_range(0, 42);
    drive(1'b1, frm[42], 1'b1);
    chk("rst done", 64'(bus.arp_rx_done), 64'd0);
    chk("rst drop", 64'(bus.drop_cnt), 64'd0);
    chk_out("rst", z);
    send_range(43, frm.size());
    gap();
    exp_drop = 0;
    chk("rst frame done count", 64'(ndone), 64'd0);
    chk("rst frame drop", 64'(bus.drop_cnt), 64'd0);
    build(vt[0]);
    start_frame();
    send_range(0, frm.size());
    gap();
    chk("post rst done count", 64'(ndone), 64'd1);
    chk("post rst done pos", 64'(dpos), 64'd49);
    chk_out("post rst", vt[0]);

    // Saturation: 17 bad-destination frames into a 4-bit counter.
    build(vt[6]);
    for (int n = 0; n < 17; n++) begin
      start_frame();
      send_range(0, frm.size());
      gap();
    end
    chk("drop saturate", 64'(bus.drop_cnt), 64'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
